// File: rtl/s2mm_bank_loader.sv
// AXI4-Stream slave that unpacks packed D_W-bit elements into one write per cycle
// for the A and B operand banks, with blocked or interleaved bank mapping.
module s2mm_bank_loader #(
  parameter int M         = 8,
  parameter int N_A       = 4,
  parameter int N_B       = 4,
  parameter int D_W       = 8,
  parameter int AXIS_W    = 32,
  parameter int BANK_MODE = 0,
  localparam int AA_W     = ((M * M) / N_A > 1) ? $clog2((M * M) / N_A) : 1,
  localparam int BA_W     = ((M * M) / N_B > 1) ? $clog2((M * M) / N_B) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AXIS_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [N_A-1:0]    a_wr_en,
  output logic [AA_W-1:0]   a_wr_addr,
  output logic [D_W-1:0]    a_wr_data,
  output logic [N_B-1:0]    b_wr_en,
  output logic [BA_W-1:0]   b_wr_addr,
  output logic [D_W-1:0]    b_wr_data,
  input  logic              restart,
  output logic              load_done,
  output logic              err_tlast
);
  localparam int MM      = M * M;
  localparam int TOTAL   = 2 * MM;
  localparam int P       = AXIS_W / D_W;
  localparam int DEPTH_A = MM / N_A;
  localparam int DEPTH_B = MM / N_B;
  localparam int E_W     = $clog2(TOTAL);
  localparam int REM_W   = $clog2(P + 1);

  typedef enum logic [1:0] {LOAD, DONE, ERROR} state_t;

  state_t              state, state_nxt;
  logic [E_W-1:0]      e_p0;
  logic [AXIS_W-1:0]   buf_p0;
  logic [REM_W-1:0]    rem_p0;
  logic                last_p0;
  logic                fin_p1;

  logic                accept, push, emit;
  logic                lane_last, beat_last, is_final, frame_err;
  logic [D_W-1:0]      lane_data;
  logic [AXIS_W-1:0]   buf_nxt;
  logic                a_sel;
  logic [N_A-1:0]      a_en_c;
  logic [N_B-1:0]      b_en_c;
  logic [AA_W-1:0]     a_addr_c;
  logic [BA_W-1:0]     b_addr_c;
  int                  j;

  function automatic int map_bank(input int idx, input int n, input int depth);
    return (BANK_MODE != 0) ? (idx % n) : (idx / depth);
  endfunction

  function automatic int map_addr(input int idx, input int n, input int depth);
    return (BANK_MODE != 0) ? (idx / n) : (idx % depth);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // A new beat is taken only once every lane of the previous one has been pushed
  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    if (!rst && !restart && rem_p0 == '0) begin
      if (state == ERROR)                s_axis_tready = 1'b1;
      else if (state == LOAD && !fin_p1) s_axis_tready = 1'b1;
    end
    accept    = s_axis_tvalid && s_axis_tready;
    push      = (state == LOAD) && (rem_p0 != '0) && !restart && !rst;
    emit      = push || (accept && state == LOAD);
    lane_data = push ? buf_p0[D_W-1:0] : s_axis_tdata[D_W-1:0];
    buf_nxt   = push ? (buf_p0 >> D_W) : (s_axis_tdata >> D_W);
    lane_last = push ? (rem_p0 == REM_W'(1)) : (P == 1);
    beat_last = push ? last_p0 : s_axis_tlast;
    is_final  = (e_p0 == E_W'(TOTAL - 1));
    frame_err = emit && lane_last && beat_last && !is_final;
    if (restart) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (fin_p1)         state_nxt = DONE;
          else if (frame_err) state_nxt = ERROR;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    a_sel    = (e_p0 < E_W'(MM));
    j        = a_sel ? int'(e_p0) : int'(e_p0) - MM;
    a_en_c   = N_A'(1) << map_bank(j, N_A, DEPTH_A);
    b_en_c   = N_B'(1) << map_bank(j, N_B, DEPTH_B);
    a_addr_c = AA_W'(map_addr(j, N_A, DEPTH_A));
    b_addr_c = BA_W'(map_addr(j, N_B, DEPTH_B));
  end

  // Stage p0: unpack buffer, lane count and global element index
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      e_p0    <= '0;
      rem_p0  <= '0;
      last_p0 <= 1'b0;
      fin_p1  <= 1'b0;
    end else begin
      fin_p1 <= emit && is_final;
      if (emit) e_p0 <= is_final ? '0 : e_p0 + E_W'(1);
      if (accept && state == LOAD) begin
        rem_p0  <= REM_W'(P - 1);
        last_p0 <= s_axis_tlast;
      end else if (push) begin
        rem_p0 <= rem_p0 - REM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (emit) buf_p0 <= buf_nxt;
  end

  // Stage p1: registered bank strobes, address, data and status
  always_ff @(posedge clk) begin
    if (rst) begin
      a_wr_en   <= '0;
      a_wr_addr <= '0;
      a_wr_data <= '0;
      b_wr_en   <= '0;
      b_wr_addr <= '0;
      b_wr_data <= '0;
      load_done <= 1'b0;
      err_tlast <= 1'b0;
    end else if (restart) begin
      a_wr_en   <= '0;
      b_wr_en   <= '0;
      load_done <= 1'b0;
      err_tlast <= 1'b0;
    end else begin
      a_wr_en <= '0;
      b_wr_en <= '0;
      if (emit) begin
        if (a_sel) begin
          a_wr_en   <= a_en_c;
          a_wr_addr <= a_addr_c;
          a_wr_data <= lane_data;
        end else begin
          b_wr_en   <= b_en_c;
          b_wr_addr <= b_addr_c;
          b_wr_data <= lane_data;
        end
      end
      if (state == LOAD && fin_p1) begin
        load_done <= 1'b1;
        if (!last_p0) err_tlast <= 1'b1;
      end
      if (frame_err) err_tlast <= 1'b1;
    end
  end

endmodule

// File: tb/tb_s2mm_bank_loader.sv
// Bench for s2mm_bank_loader: a blocked and an interleaved instance share one
// stimulus stream; their strobe logs are compared with a spec-level model.
`timescale 1ns/1ps
module tb_s2mm_bank_loader;
  localparam int MM = 64, TOT = 128, DEPTH = 16, NB = 4, AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, restart, tvalid, tlast;
  logic [AW-1:0] tdata;
  logic          tready0, tready1, done0, done1, err0, err1;
  logic [3:0]    aen0, ben0, aaddr0, baddr0, aen1, ben1, aaddr1, baddr1;
  logic [7:0]    adata0, bdata0, adata1, bdata1;

  s2mm_bank_loader #(.M(8), .N_A(4), .N_B(4), .D_W(8), .AXIS_W(32), .BANK_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(tready0),
    .a_wr_en(aen0), .a_wr_addr(aaddr0), .a_wr_data(adata0),
    .b_wr_en(ben0), .b_wr_addr(baddr0), .b_wr_data(bdata0),
    .restart(restart), .load_done(done0), .err_tlast(err0));

  s2mm_bank_loader #(.M(8), .N_A(4), .N_B(4), .D_W(8), .AXIS_W(32), .BANK_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(tready1),
    .a_wr_en(aen1), .a_wr_addr(aaddr1), .a_wr_data(adata1),
    .b_wr_en(ben1), .b_wr_addr(baddr1), .b_wr_data(bdata1),
    .restart(restart), .load_done(done1), .err_tlast(err1));

  typedef struct {
    int         cyc;
    logic [3:0] aen, ben, aaddr, baddr;
    logic [7:0] adata, bdata;
  } ent_t;

  ent_t       log0[$], log1[$];
  int         done_log[$];
  int         cyc = 0;
  int         total = 0, bad = 0;
  logic [7:0] elem [TOT];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ((aen0 | ben0) !== 4'b0) log0.push_back('{cyc, aen0, ben0, aaddr0, baddr0, adata0, bdata0});
    if ((aen1 | ben1) !== 4'b0) log1.push_back('{cyc, aen1, ben1, aaddr1, baddr1, adata1, bdata1});
    if (done0 === 1'b1) done_log.push_back(cyc);
  end

  // Reference: element e goes to operand A (j=e) or B (j=e-64); bank/addr from j
  function automatic logic [19:0] model_strobe(input int mode, input int e);
    int j, bank, addr;
    logic [3:0] en;
    j    = e % MM;
    bank = (mode != 0) ? j % NB : j / DEPTH;
    addr = (mode != 0) ? j / NB : j % DEPTH;
    en   = 4'(1 << bank);
    if (e < MM) return {en, 4'b0, 4'(addr), elem[e]};
    return {4'b0, en, 4'(addr), elem[e]};
  endfunction

  function automatic logic [19:0] obs_strobe(input ent_t x);
    return {x.aen, x.ben, (x.aen != 4'b0) ? x.aaddr : x.baddr,
            (x.aen != 4'b0) ? x.adata : x.bdata};
  endfunction

  function automatic logic [AW-1:0] beat_of(input int k);
    return {elem[4*k+3], elem[4*k+2], elem[4*k+1], elem[4*k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log0.delete();
    log1.delete();
    done_log.delete();
  endtask

  task automatic fill(input bit rnd);
    for (int i = 0; i < TOT; i++) elem[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  task automatic do_reset();
    rst = 1'b1; restart = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    clear_logs();
  endtask

  task automatic send_beat(input logic [AW-1:0] d, input bit last, input int gap,
                           output bit ok, output int acc_cyc);
    int n;
    for (int g = 0; g < gap; g++) tick();
    tdata = d; tvalid = 1'b1; tlast = last;
    ok = 1'b0; n = 0; acc_cyc = -1;
    while (!ok && n < 64) begin
      @(negedge clk);
      if (tready0 === 1'b1) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
      tick();
      n++;
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_job(input int first, input int nbeats, input int tlast_beat, input int maxgap,
                          output int miss, output int first_acc);
    bit ok;
    int ac;
    miss = 0; first_acc = -1;
    for (int k = first; k < first + nbeats; k++) begin
      send_beat(beat_of(k), k == tlast_beat, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0, ok, ac);
      if (!ok) miss++;
      if (k == first) first_acc = ac;
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done0 === 1'b1 && done1 === 1'b1) ok = 1'b1;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; restart = 1'b0; tvalid = 1'b1; tlast = 1'b0; tdata = 32'hdeadbeef;
    repeat (3) tick();
    @(negedge clk);
    total++;
    if ({aen0, ben0, aaddr0, baddr0, adata0, bdata0, done0, err0, tready0} !== 35'b0) begin
      bad++;
      $display("FAIL reset_blk got=%h want=0", {aen0, ben0, aaddr0, baddr0, adata0, bdata0, done0, err0, tready0});
    end
    total++;
    if ({aen1, ben1, aaddr1, baddr1, adata1, bdata1, done1, err1, tready1} !== 35'b0) begin
      bad++;
      $display("FAIL reset_int got=%h want=0", {aen1, ben1, aaddr1, baddr1, adata1, bdata1, done1, err1, tready1});
    end
    tick();
    tvalid = 1'b0;
    rst = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (tready0 !== 1'b1) begin bad++; $display("FAIL reset_release_tready got=%b want=1", tready0); end
    tick();
    clear_logs();
  endtask

  task automatic test_mapping();
    int miss, facc, n;
    bit ok;
    do_reset();
    fill(1'b0);
    send_job(0, 32, 31, 0, miss, facc);
    wait_done(400, ok);
    total++;
    if (miss !== 0 || ok !== 1'b1) begin bad++; $display("FAIL map_handshake got=miss%0d/done%b want=0/1", miss, ok); end
    for (int inst = 0; inst < 2; inst++) begin
      n = (inst == 0) ? log0.size() : log1.size();
      total++;
      if (n !== TOT) begin bad++; $display("FAIL map_count inst%0d got=%0d want=%0d", inst, n, TOT); end
      for (int i = 0; i < TOT && i < n; i++) begin
        ent_t x;
        if (inst == 0) x = log0[i]; else x = log1[i];
        total++;
        if (obs_strobe(x) !== model_strobe(inst, i)) begin
          bad++; $display("FAIL map_e%0d inst%0d got=%h want=%h", i, inst, obs_strobe(x), model_strobe(inst, i));
        end
      end
    end
    if (log0.size() == TOT && log1.size() == TOT && done_log.size() > 0) begin
      total++;
      if ({log0[17].aen, log0[17].aaddr, log0[17].adata} !== {4'b0010, 4'd1, 8'd17}) begin
        bad++; $display("FAIL blk_e17 got=%h want=%h", {log0[17].aen, log0[17].aaddr, log0[17].adata}, {4'b0010, 4'd1, 8'd17});
      end
      total++;
      if ({log0[64].ben, log0[64].baddr, log0[64].bdata} !== {4'b0001, 4'd0, 8'd64}) begin
        bad++; $display("FAIL blk_e64 got=%h want=%h", {log0[64].ben, log0[64].baddr, log0[64].bdata}, {4'b0001, 4'd0, 8'd64});
      end
      total++;
      if ({log1[17].aen, log1[17].aaddr} !== {4'b0010, 4'd4}) begin
        bad++; $display("FAIL int_e17 got=%h want=%h", {log1[17].aen, log1[17].aaddr}, {4'b0010, 4'd4});
      end
      total++;
      if ({log1[127].ben, log1[127].baddr} !== {4'b1000, 4'd15}) begin
        bad++; $display("FAIL int_e127 got=%h want=%h", {log1[127].ben, log1[127].baddr}, {4'b1000, 4'd15});
      end
      total++;
      if (log0[0].cyc !== facc + 1) begin bad++; $display("FAIL first_latency got=%0d want=%0d", log0[0].cyc, facc + 1); end
      total++;
      if (log0[127].cyc - log0[0].cyc !== 127) begin
        bad++; $display("FAIL throughput got=%0d want=127", log0[127].cyc - log0[0].cyc);
      end
      total++;
      if (done_log[0] !== log0[127].cyc + 1) begin
        bad++; $display("FAIL done_timing got=%0d want=%0d", done_log[0], log0[127].cyc + 1);
      end
    end else begin
      total++; bad++; $display("FAIL map_logs got=%0d/%0d want=%0d", log0.size(), log1.size(), TOT);
    end
    repeat (3) tick();
    @(negedge clk);
    total++;
    if ({tready0, tready1, err0, err1, done0, done1} !== 6'b000011) begin
      bad++; $display("FAIL map_done_state got=%b want=000011", {tready0, tready1, err0, err1, done0, done1});
    end
    tick();
  endtask

  task automatic test_gaps();
    int miss, facc, n;
    bit ok;
    do_reset();
    fill(1'b1);
    send_job(0, 32, 31, 3, miss, facc);
    wait_done(400, ok);
    total++;
    if (miss !== 0 || ok !== 1'b1) begin bad++; $display("FAIL gaps_handshake got=miss%0d/done%b want=0/1", miss, ok); end
    for (int inst = 0; inst < 2; inst++) begin
      n = (inst == 0) ? log0.size() : log1.size();
      total++;
      if (n !== TOT) begin bad++; $display("FAIL gaps_count inst%0d got=%0d want=%0d", inst, n, TOT); end
      for (int i = 0; i < TOT && i < n; i++) begin
        ent_t x;
        if (inst == 0) x = log0[i]; else x = log1[i];
        total++;
        if (obs_strobe(x) !== model_strobe(inst, i)) begin
          bad++; $display("FAIL gaps_e%0d inst%0d got=%h want=%h", i, inst, obs_strobe(x), model_strobe(inst, i));
        end
      end
    end
    total++;
    if ({err0, err1} !== 2'b00) begin bad++; $display("FAIL gaps_err got=%b want=00", {err0, err1}); end
  endtask

  task automatic test_early_tlast();
    int miss, facc, n;
    bit ok;
    do_reset();
    fill(1'b1);
    send_job(0, 11, 10, 1, miss, facc);
    send_job(11, 4, -1, 0, n, facc);
    repeat (6) tick();
    @(negedge clk);
    total++;
    if (miss !== 0 || n !== 0) begin bad++; $display("FAIL err_accept got=miss%0d/%0d want=0/0", miss, n); end
    total++;
    if ({err0, err1, done0, done1, tready0, tready1} !== 6'b110011) begin
      bad++; $display("FAIL err_state got=%b want=110011", {err0, err1, done0, done1, tready0, tready1});
    end
    for (int inst = 0; inst < 2; inst++) begin
      n = (inst == 0) ? log0.size() : log1.size();
      total++;
      if (n !== 44) begin bad++; $display("FAIL err_count inst%0d got=%0d want=44", inst, n); end
      for (int i = 0; i < 44 && i < n; i++) begin
        ent_t x;
        if (inst == 0) x = log0[i]; else x = log1[i];
        total++;
        if (obs_strobe(x) !== model_strobe(inst, i)) begin
          bad++; $display("FAIL err_e%0d inst%0d got=%h want=%h", i, inst, obs_strobe(x), model_strobe(inst, i));
        end
      end
    end
    tick();
    restart = 1'b1;
    @(negedge clk);
    total++;
    if (tready0 !== 1'b0) begin bad++; $display("FAIL err_restart_tready got=%b want=0", tready0); end
    tick();
    restart = 1'b0;
    clear_logs();
    @(negedge clk);
    total++;
    if ({err0, err1, tready0} !== 3'b001) begin bad++; $display("FAIL err_cleared got=%b want=001", {err0, err1, tready0}); end
    tick();
    fill(1'b0);
    send_job(0, 32, 31, 0, miss, facc);
    wait_done(400, ok);
    total++;
    if (miss !== 0 || ok !== 1'b1 || {err0, err1} !== 2'b00) begin
      bad++; $display("FAIL reload_status got=miss%0d/done%b/err%b want=0/1/00", miss, ok, {err0, err1});
    end
    for (int inst = 0; inst < 2; inst++) begin
      n = (inst == 0) ? log0.size() : log1.size();
      total++;
      if (n !== TOT) begin bad++; $display("FAIL reload_count inst%0d got=%0d want=%0d", inst, n, TOT); end
      for (int i = 0; i < TOT && i < n; i++) begin
        ent_t x;
        if (inst == 0) x = log0[i]; else x = log1[i];
        total++;
        if (obs_strobe(x) !== model_strobe(inst, i)) begin
          bad++; $display("FAIL reload_e%0d inst%0d got=%h want=%h", i, inst, obs_strobe(x), model_strobe(inst, i));
        end
      end
    end
  endtask

  task automatic test_missing_tlast();
    int miss, facc;
    bit ok;
    do_reset();
    fill(1'b1);
    send_job(0, 32, -1, 1, miss, facc);
    wait_done(400, ok);
    total++;
    if (miss !== 0 || ok !== 1'b1) begin bad++; $display("FAIL notlast_handshake got=miss%0d/done%b want=0/1", miss, ok); end
    total++;
    if ({done0, done1, err0, err1} !== 4'b1111) begin
      bad++; $display("FAIL notlast_flags got=%b want=1111", {done0, done1, err0, err1});
    end
    total++;
    if (log0.size() !== TOT || log1.size() !== TOT) begin
      bad++; $display("FAIL notlast_count got=%0d/%0d want=%0d", log0.size(), log1.size(), TOT);
    end
  endtask

  task automatic test_back_to_back();
    int miss, facc, n;
    bit ok;
    tick();
    restart = 1'b1;
    @(negedge clk);
    total++;
    if (tready0 !== 1'b0) begin bad++; $display("FAIL b2b_restart_tready got=%b want=0", tready0); end
    tick();
    restart = 1'b0;
    clear_logs();
    @(negedge clk);
    total++;
    if ({done0, done1, err0, err1, tready0, tready1} !== 6'b000011) begin
      bad++; $display("FAIL b2b_after_restart got=%b want=000011", {done0, done1, err0, err1, tready0, tready1});
    end
    tick();
    fill(1'b1);
    send_job(0, 32, 31, 2, miss, facc);
    wait_done(400, ok);
    total++;
    if (miss !== 0 || ok !== 1'b1 || {err0, err1} !== 2'b00) begin
      bad++; $display("FAIL b2b_status got=miss%0d/done%b/err%b want=0/1/00", miss, ok, {err0, err1});
    end
    for (int inst = 0; inst < 2; inst++) begin
      n = (inst == 0) ? log0.size() : log1.size();
      total++;
      if (n !== TOT) begin bad++; $display("FAIL b2b_count inst%0d got=%0d want=%0d", inst, n, TOT); end
      for (int i = 0; i < TOT && i < n; i++) begin
        ent_t x;
        if (inst == 0) x = log0[i]; else x = log1[i];
        total++;
        if (obs_strobe(x) !== model_strobe(inst, i)) begin
          bad++; $display("FAIL b2b_e%0d inst%0d got=%h want=%h", i, inst, obs_strobe(x), model_strobe(inst, i));
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    int miss, facc, n;
    bit ok;
    do_reset();
    fill(1'b0);
    send_job(0, 13, -1, 0, miss, facc);
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({aen0, aaddr0, adata0, aen1, aaddr1} !== {4'b1000, 4'd2, 8'd50, 4'b0100, 4'd12}) begin
      bad++; $display("FAIL rstmid_e50 got=%h want=%h", {aen0, aaddr0, adata0, aen1, aaddr1}, {4'b1000, 4'd2, 8'd50, 4'b0100, 4'd12});
    end
    tick();
    @(negedge clk);
    total++;
    if ({aen0, ben0, aen1, ben1, tready0} !== 17'b0) begin
      bad++; $display("FAIL rstmid_quiet got=%h want=0", {aen0, ben0, aen1, ben1, tready0});
    end
    tick();
    rst = 1'b0;
    tick();
    clear_logs();
    send_job(0, 32, 31, 0, miss, facc);
    wait_done(400, ok);
    total++;
    if (miss !== 0 || ok !== 1'b1) begin bad++; $display("FAIL rstmid_handshake got=miss%0d/done%b want=0/1", miss, ok); end
    total++;
    if (log0.size() < 1 || {log0[0].aen, log0[0].aaddr, log0[0].adata} !== {4'b0001, 4'd0, 8'd0}) begin
      bad++; $display("FAIL rstmid_first got=%0d entries want=first a_wr_en=0001 addr=0", log0.size());
    end
    for (int inst = 0; inst < 2; inst++) begin
      n = (inst == 0) ? log0.size() : log1.size();
      total++;
      if (n !== TOT) begin bad++; $display("FAIL rstmid_count inst%0d got=%0d want=%0d", inst, n, TOT); end
      for (int i = 0; i < TOT && i < n; i++) begin
        ent_t x;
        if (inst == 0) x = log0[i]; else x = log1[i];
        total++;
        if (obs_strobe(x) !== model_strobe(inst, i)) begin
          bad++; $display("FAIL rstmid_e%0d inst%0d got=%h want=%h", i, inst, obs_strobe(x), model_strobe(inst, i));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; restart = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    test_reset();
    test_mapping();
    test_gaps();
    test_early_tlast();
    test_missing_tlast();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
